// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer and its helpers.
package pll_reset_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam int DEF_SYNC_STAGES         = 2;
   localparam int DEF_PLL_RST_CYCLES      = 16;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_RESET_HOLD_CYCLES   = 256;
   localparam int DEF_CNT_W               = 8;

   // The timer only ever reaches (largest cycle count - 1), so clog2 of the
   // largest count is enough; never narrower than one bit.
   function automatic int timer_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (m <= 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// N-stage flip-flop synchroniser for a single asynchronous status bit.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic d,
   output logic q
);

   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("sync_bit: STAGES must be at least 2");
      end
   endgenerate

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], d};
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock debounce and system reset release, with
// saturating counters of lock timeouts and lock drops.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_reset,
   output logic             sys_ready,
   output logic [CNT_W-1:0] lock_loss_count,
   output logic [CNT_W-1:0] retry_count
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("pll_reset_sequencer: SYNC_STAGES must be at least 2");
      end
      if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
          LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1) begin : g_bad_cycles
         $error("pll_reset_sequencer: every *_CYCLES parameter must be at least 1");
      end
   endgenerate

   localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);

   localparam logic [TW-1:0]    RST_LAST     = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]    STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0]    HOLD_LAST    = TW'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   logic             lk;
   state_t           state_reg, state_next;
   logic [TW-1:0]    timer_reg, timer_next;
   logic [CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
   logic [CNT_W-1:0] retry_cnt_reg, retry_cnt_next;
   logic             pll_rst_reg, sys_reset_reg, sys_ready_reg;
   logic             retry_inc, loss_inc;

   // pll_locked is only ever observed through this synchroniser.
   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk  (clk),
      .srst (rst),
      .d    (pll_locked),
      .q    (lk)
   );

   always_comb begin
      state_next = state_reg;
      retry_inc  = 1'b0;
      loss_inc   = 1'b0;
      case (state_reg)
         PLL_RST: begin
            if (timer_reg == RST_LAST) state_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // Lock takes precedence over a timeout landing on the same cycle.
            if (lk) begin
               state_next = STABLE;
            end else if (timer_reg == TIMEOUT_LAST) begin
               state_next = PLL_RST;
               retry_inc  = 1'b1;
            end
         end
         STABLE: begin
            if (!lk) begin
               state_next = WAIT_LOCK;
            end else if (timer_reg == STABLE_LAST) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (!lk) begin
               state_next = WAIT_LOCK;
               loss_inc   = 1'b1;
            end else if (timer_reg == HOLD_LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (!lk) begin
               state_next = WAIT_LOCK;
               loss_inc   = 1'b1;
            end
         end
         default: begin
            state_next = PLL_RST;
         end
      endcase
   end

   // RUN has no timed exit, so the timer parks there instead of wrapping.
   always_comb begin
      timer_next = timer_reg;
      if (state_next != state_reg) begin
         timer_next = '0;
      end else if (state_reg != RUN) begin
         timer_next = timer_reg + 1'b1;
      end
   end

   always_comb begin
      loss_cnt_next  = loss_cnt_reg;
      retry_cnt_next = retry_cnt_reg;
      if (loss_inc && loss_cnt_reg != CNT_MAX) begin
         loss_cnt_next = loss_cnt_reg + 1'b1;
      end
      if (retry_inc && retry_cnt_reg != CNT_MAX) begin
         retry_cnt_next = retry_cnt_reg + 1'b1;
      end
   end

   // Outputs decode the next state so they move on the same edge as state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= PLL_RST;
         timer_reg     <= '0;
         loss_cnt_reg  <= '0;
         retry_cnt_reg <= '0;
         pll_rst_reg   <= 1'b1;
         sys_reset_reg <= 1'b1;
         sys_ready_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         loss_cnt_reg  <= loss_cnt_next;
         retry_cnt_reg <= retry_cnt_next;
         pll_rst_reg   <= (state_next == PLL_RST);
         sys_reset_reg <= (state_next != RUN);
         sys_ready_reg <= (state_next == RUN);
      end
   end

   assign pll_rst         = pll_rst_reg;
   assign sys_reset       = sys_reset_reg;
   assign sys_ready       = sys_ready_reg;
   assign lock_loss_count = loss_cnt_reg;
   assign retry_count     = retry_cnt_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with short cycle counts.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_reset;
   logic       sys_ready;
   logic [7:0] lock_loss_count;
   logic [7:0] retry_count;

   int n_cmp  = 0;
   int n_fail = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES         (2),
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (100),
      .LOCK_STABLE_CYCLES  (8),
      .RESET_HOLD_CYCLES   (16),
      .CNT_W               (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .sys_reset       (sys_reset),
      .sys_ready       (sys_ready),
      .lock_loss_count (lock_loss_count),
      .retry_count     (retry_count)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic exp;
      rst = 1'b1;
      pll_locked = 1'b0;
      step(3);
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset: got %b want 1", sys_reset); end
      n_cmp++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sys_ready: got %b want 0", sys_ready); end
      n_cmp++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", lock_loss_count); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         exp = (i < 4);
         n_cmp++; if (pll_rst !== exp) begin n_fail++; $display("FAIL release_pll_rst edge %0d: got %b want %b", i, pll_rst, exp); end
      end
      $display("test_reset done");
   endtask

   task automatic test_lock();
      logic exp_rst;
      step(10);
      pll_locked = 1'b1;
      for (int i = 1; i <= 27; i++) begin
         step(1);
         exp_rst = (i < 27);
         n_cmp++; if (sys_reset !== exp_rst) begin n_fail++; $display("FAIL lock_sys_reset edge %0d: got %b want %b", i, sys_reset, exp_rst); end
         n_cmp++; if (sys_ready !== !exp_rst) begin n_fail++; $display("FAIL lock_sys_ready edge %0d: got %b want %b", i, sys_ready, !exp_rst); end
         n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL lock_pll_rst edge %0d: got %b want 0", i, pll_rst); end
      end
      $display("test_lock done");
   endtask

   task automatic test_lock_loss();
      logic exp_rst;
      pll_locked = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         exp_rst = (i >= 3);
         n_cmp++; if (sys_reset !== exp_rst) begin n_fail++; $display("FAIL drop_sys_reset edge %0d: got %b want %b", i, sys_reset, exp_rst); end
         n_cmp++; if (sys_ready !== !exp_rst) begin n_fail++; $display("FAIL drop_sys_ready edge %0d: got %b want %b", i, sys_ready, !exp_rst); end
         if (i == 3) begin
            n_cmp++; if (lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL drop_loss_count: got %0d want 1", lock_loss_count); end
         end
      end
      pll_locked = 1'b1;
      for (int i = 1; i <= 27; i++) begin
         step(1);
         exp_rst = (i < 27);
         n_cmp++; if (sys_ready !== !exp_rst) begin n_fail++; $display("FAIL relock_sys_ready edge %0d: got %b want %b", i, sys_ready, !exp_rst); end
      end
      n_cmp++; if (lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL relock_loss_count: got %0d want 1", lock_loss_count); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL relock_retry_count: got %0d want 0", retry_count); end
      $display("test_lock_loss done");
   endtask

   task automatic test_stable_glitch();
      logic exp_rst;
      pll_locked = 1'b0;
      step(5);
      n_cmp++; if (lock_loss_count !== 8'd2) begin n_fail++; $display("FAIL glitch_pre_loss: got %0d want 2", lock_loss_count); end
      pll_locked = 1'b1;
      step(6);
      // Drop lands on lk while the debounce timer reads 5.
      pll_locked = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         n_cmp++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL glitch_sys_reset edge %0d: got %b want 1", i, sys_reset); end
         n_cmp++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL glitch_sys_ready edge %0d: got %b want 0", i, sys_ready); end
      end
      n_cmp++; if (lock_loss_count !== 8'd2) begin n_fail++; $display("FAIL glitch_loss: got %0d want 2", lock_loss_count); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d want 0", retry_count); end
      pll_locked = 1'b1;
      for (int i = 1; i <= 27; i++) begin
         step(1);
         exp_rst = (i < 27);
         n_cmp++; if (sys_reset !== exp_rst) begin n_fail++; $display("FAIL redebounce_sys_reset edge %0d: got %b want %b", i, sys_reset, exp_rst); end
      end
      n_cmp++; if (lock_loss_count !== 8'd2) begin n_fail++; $display("FAIL redebounce_loss: got %0d want 2", lock_loss_count); end
      $display("test_stable_glitch done");
   endtask

   task automatic test_rst_in_run();
      rst = 1'b1;
      step(1);
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL run_rst_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL run_rst_sys_reset: got %b want 1", sys_reset); end
      n_cmp++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL run_rst_sys_ready: got %b want 0", sys_ready); end
      n_cmp++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL run_rst_loss: got %0d want 0", lock_loss_count); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL run_rst_retry: got %0d want 0", retry_count); end
      $display("test_rst_in_run done");
   endtask

   task automatic test_retry();
      logic exp;
      int   exp_cnt;
      int   last;
      last = 104 * 257 + 4;
      pll_locked = 1'b0;
      step(1);
      rst = 1'b0;
      for (int e = 1; e <= last; e++) begin
         step(1);
         if (e <= 220) begin
            exp = ((e % 104) <= 3);
            n_cmp++; if (pll_rst !== exp) begin n_fail++; $display("FAIL retry_pll_rst edge %0d: got %b want %b", e, pll_rst, exp); end
         end
         if ((e % 104) == 0) begin
            exp_cnt = (e / 104 > 255) ? 255 : e / 104;
            n_cmp++; if (retry_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL retry_count edge %0d: got %0d want %0d", e, retry_count, exp_cnt); end
         end
      end
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL retry_final_pll_rst: got %b want 0", pll_rst); end
      n_cmp++; if (retry_count !== 8'd255) begin n_fail++; $display("FAIL retry_saturated: got %0d want 255", retry_count); end
      $display("test_retry done");
   endtask

   task automatic test_rst_in_hold();
      pll_locked = 1'b1;
      step(15);
      n_cmp++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL hold_pre_sys_reset: got %b want 1", sys_reset); end
      n_cmp++; if (retry_count !== 8'd255) begin n_fail++; $display("FAIL hold_pre_retry: got %0d want 255", retry_count); end
      rst = 1'b1;
      step(1);
      n_cmp++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL hold_rst_pll_rst: got %b want 1", pll_rst); end
      n_cmp++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL hold_rst_sys_reset: got %b want 1", sys_reset); end
      n_cmp++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL hold_rst_sys_ready: got %b want 0", sys_ready); end
      n_cmp++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL hold_rst_loss: got %0d want 0", lock_loss_count); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL hold_rst_retry: got %0d want 0", retry_count); end
      $display("test_rst_in_hold done");
   endtask

   task automatic test_timeout_vs_lock();
      pll_locked = 1'b0;
      step(1);
      rst = 1'b0;
      step(4);
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL tie_pll_rst_fall: got %b want 0", pll_rst); end
      // First sample high at WAIT_LOCK edge 98, so lk rises exactly on expiry.
      step(97);
      pll_locked = 1'b1;
      step(3);
      n_cmp++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL tie_pll_rst: got %b want 0", pll_rst); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL tie_retry: got %0d want 0", retry_count); end
      step(23);
      n_cmp++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL tie_ready_early: got %b want 0", sys_ready); end
      step(1);
      n_cmp++; if (sys_ready !== 1'b1) begin n_fail++; $display("FAIL tie_ready: got %b want 1", sys_ready); end
      n_cmp++; if (retry_count !== 8'd0) begin n_fail++; $display("FAIL tie_retry_end: got %0d want 0", retry_count); end
      $display("test_timeout_vs_lock done");
   endtask

   initial begin
      test_reset();
      test_lock();
      test_lock_loss();
      test_stable_glitch();
      test_rst_in_run();
      test_retry();
      test_rst_in_hold();
      test_timeout_vs_lock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the system PLL from its free-running 50 MHz reference clock. Drives the PLL's reset input and consumes its asynchronous lock output. Produces a debounced, stretched system reset and a ready flag for the Nios II system. Retries the PLL on lock timeout and counts lock-loss and retry events for software visibility.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronising pll_locked into clk (minimum 2)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (minimum 1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before re-resetting the PLL (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronised lock required before releasing
RESET_HOLD_CYCLES, 256, cycles sys_reset stays high after lock is declared stable
CNT_W, 8, width of the saturating event counters

Ports:
clk  in  1  50 MHz reference clock, the same net that feeds the PLL refclk
rst  in  1  synchronous, active-high block reset
pll_locked  in  1  PLL lock indication; asynchronous to clk
pll_rst  out  1  reset to the PLL, active-high
sys_reset  out  1  system reset request, active-high; the 200 MHz domain resynchronises it locally
sys_ready  out  1  high only while the PLL is locked and the system is released
lock_loss_count  out  CNT_W  saturating count of lock drops seen in HOLD or RUN
retry_count  out  CNT_W  saturating count of lock timeouts

Behaviour:
- All outputs are registered. Synchronous, active-high reset; rst has priority over every other event.
- Reset values:
  - state = PLL_RST
  - pll_rst = 1, sys_reset = 1, sys_ready = 0
  - lock_loss_count = 0, retry_count = 0
  - timer = 0, all synchroniser flops = 0
- pll_locked passes through a SYNC_STAGES-deep synchroniser to produce lk. No other logic samples pll_locked directly.
- A single timer is used in every state. It clears on every state transition.
- States and transitions:
  - PLL_RST: pll_rst = 1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK. lk is ignored in this state.
  - WAIT_LOCK: pll_rst = 0.
    - lk = 1: go to STABLE.
    - Otherwise, when timer = LOCK_TIMEOUT_CYCLES-1: go to PLL_RST and increment retry_count.
    - If both happen in the same cycle, lock wins.
  - STABLE:
    - lk = 0: go to WAIT_LOCK. No counter changes.
    - After LOCK_STABLE_CYCLES consecutive cycles with lk = 1: go to HOLD.
  - HOLD:
    - lk = 0: go to WAIT_LOCK and increment lock_loss_count.
    - After RESET_HOLD_CYCLES cycles: go to RUN.
  - RUN:
    - lk = 0: go to WAIT_LOCK and increment lock_loss_count.
- Output decode is registered from next-state, so outputs change on the same edge as the state:
  - sys_reset = 1 in every state except RUN.
  - sys_ready = 1 only in RUN.
  - pll_rst = 1 only in PLL_RST.
- Latencies (counted in clk edges):
  - From the first edge at which pll_locked is sampled high to sys_reset falling: SYNC_STAGES + 1 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES.
  - From pll_locked falling to sys_reset rising: SYNC_STAGES + 1.
- Counters saturate at 2^CNT_W - 1 and never wrap. They clear only on rst.
- A lock glitch shorter than SYNC_STAGES cycles may or may not be seen. Any glitch that reaches lk restarts the debounce.
- rst asserted mid-operation forces the full reset values on the next edge, including re-pulsing pll_rst.
- Elaboration error if any *_CYCLES parameter is < 1 or SYNC_STAGES < 2.

Decomposition:
- Package pll_reset_pkg holds:
  - the state enum: PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN
  - default cycle constants
  - a helper function for the timer width: clog2 of the largest *_CYCLES value
- One sub-module, sync_bit: a parameterised N-stage synchroniser with synchronous active-high reset to 0. It is reused elsewhere for other asynchronous status inputs.

Test Plan:
Tests 2-6 use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=16.
1. rst high for 3 cycles, then low, with pll_locked=0 -> during rst: pll_rst=1, sys_reset=1, sys_ready=0, counters=0. After release: pll_rst stays high exactly 4 cycles, then falls.
2. pll_locked rises 10 cycles after pll_rst falls and stays high -> sys_reset falls and sys_ready rises exactly 27 edges after pll_locked is first sampled high. pll_rst remains 0.
3. pll_locked held 0 -> pll_rst re-pulses for 4 cycles every 104 cycles. retry_count increments once per pulse and saturates at 255 without wrapping.
4. In RUN, pll_locked drops for 5 cycles -> sys_reset=1 and sys_ready=0 three edges after the drop. lock_loss_count increments by exactly 1. The full 8+16 sequence repeats after re-lock.
5. In STABLE, pll_locked drops at debounce count 5 -> return to WAIT_LOCK, no counter change, sys_reset never deasserts. Re-lock restarts the debounce from 0.
6. rst asserted in RUN and in HOLD -> next edge: pll_rst=1, sys_reset=1, sys_ready=0, both counters=0. WAIT_LOCK timer expiry coinciding with lk rising -> goes to STABLE, retry_count unchanged.
